sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 1Mx16 external SRAM between two requesters: the SLC-3 CPU memory port and a program-loader/DMA port. The loader fills memory while the CPU runs or halts.
- Sits between the requesters and the tristate data buffer.
- Owns all SRAM strobes (CE/OE/WE/UB/LB), the 20-bit address and the tristate output enable.
- Sequences each access through a fixed-timing FSM with a configurable wait-state count.

Parameters:
- WAIT_CYCLES, 2: number of ACCESS-state cycles per transfer (1..15).
- ADDR_W, 20: SRAM address width.

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU word address; zero-extended to ADDR_W.
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  read data, valid in the cpu_ack cycle and held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- ldr_req  in  1  loader request.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  16  loader write data.
- ldr_rdata  out  16  loader read data, same rules as cpu_rdata.
- ldr_ack  out  1  loader completion pulse.
- Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  out  1 each  active-low SRAM strobes.
- ADDR  out  ADDR_W  SRAM address.
- Data_write  out  16  data to the tristate buffer.
- Data_read  in  16  data from the tristate buffer.
- Data_oe  out  1  tristate drive enable (1 = drive bus).
- owner  out  1  current grant: 0 = CPU, 1 = loader.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately even mid-access):
  - all strobes 1; ADDR 0; Data_write 0; Data_oe 0.
  - both acks 0; both rdata 0; owner 0; busy 0; state IDLE; last-grant 0.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. Every transfer passes through all four states.
- IDLE:
  - strobes high, Data_oe 0.
  - If any request is pending, arbitrate, then latch owner, we, address and wdata into internal registers and go to SETUP.
  - Requester fields are sampled only at this edge; later changes are ignored until the next grant.
- SETUP (1 cycle):
  - ADDR valid, Mem_CE=0, UB=LB=0.
  - Read: Mem_OE=0. Write: Mem_OE=1 and Data_oe=1 with Data_write=latched wdata. Mem_WE=1 for both.
- ACCESS (WAIT_CYCLES cycles, counted by a down-counter):
  - Writes drive Mem_WE=0.
  - Reads capture Data_read into the owner's rdata register on the last ACCESS cycle's clock edge.
- DONE (1 cycle):
  - Mem_WE=1; CE/OE/ADDR and Data_oe unchanged from ACCESS, so write data is held after the WE rising edge.
  - Owner's ack=1; the other ack stays 0.
- Timing:
  - Latency: req sampled at edge N -> ack high in cycle N+2+WAIT_CYCLES. With the default, ack is 4 cycles after grant.
  - Minimum back-to-back period: 3+WAIT_CYCLES cycles, because one IDLE cycle separates transfers.
- Requester rules:
  - Deassert req in the cycle after ack, or keep it high to request another transfer.
  - A req still high in the IDLE cycle after DONE is a new request.
- Arbitration, fixed priority (default): the CPU wins whenever cpu_req=1. A simultaneous request waits in IDLE until the CPU releases.
- Address width: cpu_addr maps to {4'b0, cpu_addr}; ldr_addr is used as-is.
- Reset mid-operation: no ack is emitted; after release, the FSM starts in IDLE and requesters must re-request.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: when both req are high in IDLE, grant the requester that did not win the previous grant (last-grant register, reset 0 = CPU last, so the loader wins the first tie). A lone requester is always granted.
- Undefined: fixed CPU priority as above; the last-grant register is not built.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum arb_state_t {IDLE, SETUP, ACCESS, DONE};
  - owner enum owner_t {OWN_CPU, OWN_LDR};
  - localparam WAIT_W = 4 for the counter width.
- One natural sub-module: sram_arb_timer, a loadable down-counter that asserts last-cycle when the count reaches 1. Arbitration and the FSM stay in the top module.

Test Plan:
- CPU read, addr 0x1234, SRAM model returns 0xBEEF -> ADDR=0x01234, OE=0 for SETUP+ACCESS, cpu_ack 4 cycles after grant, cpu_rdata=0xBEEF, ldr_ack never pulses.
- Loader write, addr 0xF0010, data 0xA5A5 -> Data_oe=1 from SETUP through DONE, WE=0 exactly 2 cycles, OE=1 throughout, ldr_ack pulses once; a CPU read of 0x0010 then returns 0xA5A5.
- Both requests asserted and held for 3 transfers -> default build: owner stays CPU with 3 cpu_acks; with SRAM_ARB_ROUND_ROBIN_EN: grants alternate LDR, CPU, LDR.
- Back-to-back CPU reads with req held high -> acks spaced exactly 5 cycles apart; IDLE visible (busy=0) for one cycle between transfers.
- Reset asserted during ACCESS of a write -> WE, CE and Data_oe return high/0 within the same cycle with no clock edge needed, no ack; after release, a CPU read of 0x0000 completes normally.
- WAIT_CYCLES=5, CPU read -> WE stays 1, read data captured on the 5th ACCESS edge, ack 7 cycles after grant.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/sram_arb_timer.sv
// Loadable down-counter that times the ACCESS phase; last_o marks the final cycle.
module sram_arb_timer
  import sram_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              last_o
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == WAIT_W'(1));

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external 1Mx16 SRAM (CPU and loader/DMA).
// Define SRAM_ARB_ROUND_ROBIN_EN to break ties by alternating grants instead of CPU priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [15:0]       ldr_wdata,
  output logic [15:0]       ldr_rdata,
  output logic              ldr_ack,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_write,
  input  logic [15:0]       Data_read,
  output logic              Data_oe,
  output logic              owner,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       cpu_rdata_q, cpu_rdata_d;
  logic [15:0]       ldr_rdata_q, ldr_rdata_d;
  logic              grant_ldr;
  logic              timer_last;
  logic              capture;

  // Arbitration: evaluated every cycle, but only acted on in IDLE.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  assign grant_ldr = ldr_req && (!cpu_req || (last_q == OWN_CPU));

  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && (cpu_req || ldr_req)) begin
      last_d = grant_ldr ? OWN_LDR : OWN_CPU;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_q <= OWN_CPU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_ldr = ldr_req && !cpu_req;
`endif

  sram_arb_timer u_timer (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .load_i     (state_q == SETUP),
    .en_i       (state_q == ACCESS),
    .load_val_i (WAIT_W'(WAIT_CYCLES)),
    .last_o     (timer_last)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          owner_d = grant_ldr ? OWN_LDR : OWN_CPU;
          we_d    = grant_ldr ? ldr_we : cpu_we;
          addr_d  = grant_ldr ? ldr_addr : ADDR_W'(cpu_addr);
          wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (timer_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands on the final ACCESS edge and is held until the owner's next read.
  assign capture = (state_q == ACCESS) && timer_last && !we_q;

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    if (capture) begin
      if (owner_q == OWN_LDR) begin
        ldr_rdata_d = Data_read;
      end else begin
        cpu_rdata_d = Data_read;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset releases the bus at once.
  always_comb begin
    Mem_CE  = 1'b1;
    Mem_OE  = 1'b1;
    Mem_WE  = 1'b1;
    Mem_UB  = 1'b1;
    Mem_LB  = 1'b1;
    Data_oe = 1'b0;
    cpu_ack = 1'b0;
    ldr_ack = 1'b0;
    if (state_q != IDLE) begin
      Mem_CE  = 1'b0;
      Mem_UB  = 1'b0;
      Mem_LB  = 1'b0;
      Mem_OE  = we_q;
      Data_oe = we_q;
    end
    if (state_q == ACCESS) begin
      Mem_WE = ~we_q;
    end
    if (state_q == DONE) begin
      cpu_ack = (owner_q == OWN_CPU);
      ldr_ack = (owner_q == OWN_LDR);
    end
  end

  assign ADDR       = addr_q;
  assign Data_write = wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-wait DUT plus a WAIT_CYCLES=5 instance.
module tb_sram_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [19:0] ldr_addr = '0;
  logic [15:0] ldr_wdata = '0;
  logic        cpu_req2 = 1'b0;

  logic [15:0] cpu_rdata, ldr_rdata, data_write, data_read;
  logic        cpu_ack, ldr_ack, mem_ce, mem_oe, mem_we, mem_ub, mem_lb, data_oe, owner, busy;
  logic [19:0] addr;

  logic [15:0] cpu_rdata2, ldr_rdata2, data_write2, data_read2;
  logic        cpu_ack2, ldr_ack2, mem_ce2, mem_oe2, mem_we2, mem_ub2, mem_lb2, data_oe2;
  logic        owner2, busy2;
  logic [19:0] addr2;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic [2:0] ExpSeq = 3'b101;
`else
  localparam logic [2:0] ExpSeq = 3'b000;
`endif

  always #5 Clk = ~Clk;

  sram_arbiter u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .Mem_CE(mem_ce), .Mem_OE(mem_oe), .Mem_WE(mem_we), .Mem_UB(mem_ub), .Mem_LB(mem_lb),
    .ADDR(addr), .Data_write(data_write), .Data_read(data_read), .Data_oe(data_oe),
    .owner(owner), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(5), .ADDR_W(20)) u_dut5 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(20'h0), .ldr_wdata(16'h0),
    .ldr_rdata(ldr_rdata2), .ldr_ack(ldr_ack2),
    .Mem_CE(mem_ce2), .Mem_OE(mem_oe2), .Mem_WE(mem_we2), .Mem_UB(mem_ub2), .Mem_LB(mem_lb2),
    .ADDR(addr2), .Data_write(data_write2), .Data_read(data_read2), .Data_oe(data_oe2),
    .owner(owner2), .busy(busy2)
  );

  // SRAM model: 64Kx16 part, upper address lines unconnected so 0xF0010 aliases 0x0010.
  logic [15:0] mem [65536];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;

  always @(posedge Clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!mem_ce && !mem_we) mem[addr[15:0]] <= data_write;
  end

  assign data_read  = (!mem_ce && !mem_oe) ? mem[addr[15:0]] : 16'h0000;
  assign data_read2 = (!mem_ce2 && !mem_oe2) ? mem[addr2[15:0]] : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sram_load(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge Clk);
    pre_en   = 1'b0;
  endtask

  // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic xfer(input bit ldr, input bit we, input logic [19:0] a, input logic [15:0] wd,
                      output int lat, output int oe_cnt, output int we_cnt, output int doe_cnt,
                      output int other_ack, output logic [19:0] a_seen, output logic [15:0] rd);
    lat = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; other_ack = 0; a_seen = '0; rd = '0;
    if (ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a[15:0]; cpu_wdata = wd;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (i == 1) a_seen = addr;
      if (!mem_oe) oe_cnt++;
      if (!mem_we) we_cnt++;
      if (data_oe) doe_cnt++;
      if (ldr ? cpu_ack : ldr_ack) other_ack++;
      if (ldr ? ldr_ack : cpu_ack) begin
        lat = i;
        rd  = ldr ? ldr_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, oe_c, we_c, doe_c, oth;
    logic [19:0] a_seen;
    logic [15:0] rd, rd_pre;
    logic [2:0]  seq;
    int k, t[3], idle_between, acks;

    @(negedge Clk);
    sram_load(16'h1234, 16'hBEEF);
    sram_load(16'h0000, 16'h1357);
    sram_load(16'h0077, 16'h7777);
    sram_load(16'h0200, 16'h2222);

    check_eq("rst_strobes", {mem_ce, mem_oe, mem_we, mem_ub, mem_lb}, 5'b11111);
    check_eq("rst_addr", addr, 20'h0);
    check_eq("rst_wdata_oe", {data_write, data_oe}, 17'h0);
    check_eq("rst_acks_owner_busy", {cpu_ack, ldr_ack, owner, busy}, 4'b0000);
    check_eq("rst_rdata", {cpu_rdata, ldr_rdata}, 32'h0);

    Reset = 1'b1;
    @(negedge Clk);

    // CPU read of 0x1234
    xfer(1'b0, 1'b0, 20'h01234, 16'h0, lat, oe_c, we_c, doe_c, oth, a_seen, rd);
    check_eq("rd_latency", lat, 4);
    check_eq("rd_addr", a_seen, 20'h01234);
    check_eq("rd_oe_cycles", oe_c, 4);
    check_eq("rd_we_cycles", we_c, 0);
    check_eq("rd_ldr_ack", oth, 0);
    check_eq("rd_data", rd, 16'hBEEF);
    check_eq("rd_idle_after", {cpu_ack, busy}, 2'b00);
    check_eq("rd_data_held", cpu_rdata, 16'hBEEF);

    // Loader write 0xA5A5 to 0xF0010, then CPU reads it back via alias 0x0010
    xfer(1'b1, 1'b1, 20'hF0010, 16'hA5A5, lat, oe_c, we_c, doe_c, oth, a_seen, rd);
    check_eq("wr_latency", lat, 4);
    check_eq("wr_addr", a_seen, 20'hF0010);
    check_eq("wr_oe_cycles", oe_c, 0);
    check_eq("wr_we_cycles", we_c, 2);
    check_eq("wr_doe_cycles", doe_c, 4);
    check_eq("wr_cpu_ack", oth, 0);
    xfer(1'b0, 1'b0, 20'h00010, 16'h0, lat, oe_c, we_c, doe_c, oth, a_seen, rd);
    check_eq("wr_readback", rd, 16'hA5A5);

    // Both requesters held for three transfers; last grant so far was the CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h00200;
    seq = '0; k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge Clk);
      if (cpu_ack || ldr_ack) begin
        seq[k] = ldr_ack;
        if (k == 2) check_eq("arb_owner_last", owner, ExpSeq[2]);
        k++;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    @(negedge Clk);
    check_eq("arb_count", k, 3);
    check_eq("arb_sequence", seq, ExpSeq);

    // Back-to-back CPU reads with req held
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    acks = 0; idle_between = 0; t[0] = 0; t[1] = 0; t[2] = 0;
    for (int i = 0; i < 40 && acks < 3; i++) begin
      @(negedge Clk);
      if (acks == 1 && !busy) idle_between++;
      if (cpu_ack) begin
        t[acks] = i;
        acks++;
      end
    end
    cpu_req = 1'b0;
    @(negedge Clk);
    check_eq("b2b_gap1", t[1] - t[0], 5);
    check_eq("b2b_gap2", t[2] - t[1], 5);
    check_eq("b2b_idle", idle_between, 1);

    // Reset mid-ACCESS of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h5555;
    @(negedge Clk);
    @(negedge Clk);
    check_eq("mid_we_low", mem_we, 1'b0);
    #1 Reset = 1'b0;
    #1;
    check_eq("mid_strobes", {mem_ce, mem_oe, mem_we, mem_ub, mem_lb}, 5'b11111);
    check_eq("mid_doe_busy", {data_oe, busy}, 2'b00);
    check_eq("mid_rdata", cpu_rdata, 16'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (cpu_ack || ldr_ack) acks++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    if (cpu_ack || ldr_ack) acks++;
    check_eq("mid_no_ack", acks, 0);
    xfer(1'b0, 1'b0, 20'h00000, 16'h0, lat, oe_c, we_c, doe_c, oth, a_seen, rd);
    check_eq("post_rst_latency", lat, 4);
    check_eq("post_rst_data", rd, 16'h1357);

    // WAIT_CYCLES=5 instance: CPU read of 0x0077
    cpu_addr = 16'h0077; cpu_we = 1'b0; cpu_req2 = 1'b1;
    lat = 0; we_c = 0; rd = '0; rd_pre = 16'hFFFF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (!mem_we2) we_c++;
      if (i == 6) rd_pre = cpu_rdata2;
      if (cpu_ack2) begin
        lat = i;
        rd  = cpu_rdata2;
        break;
      end
    end
    cpu_req2 = 1'b0;
    @(negedge Clk);
    check_eq("w5_latency", lat, 7);
    check_eq("w5_we_cycles", we_c, 0);
    check_eq("w5_rdata_before_last", rd_pre, 16'h0);
    check_eq("w5_rdata", rd, 16'h7777);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
